// File: rtl/lsb_queue.sv
// lsb_queue: parametrised in-order load/store queue.
// Circular buffer of LSB_DEPTH memory ops that snoops NUM_CDB result buses,
// issues head-only memory accesses and returns load data on the res_* port.
// Build option: define LSB_STALL_CNT_EN to add the perf_stall_cnt output.
module lsb_queue #(
    parameter int LSB_DEPTH = 16,
    parameter int TAG_W     = 5,
    parameter int DATA_W    = 32,
    parameter int NUM_CDB   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [TAG_W-1:0]          issue_dest,
    input  logic                      issue_is_store,
    input  logic [2:0]                issue_funct3,
    input  logic [TAG_W-1:0]          issue_rs1_tag,
    input  logic [DATA_W-1:0]         issue_rs1_data,
    input  logic [TAG_W-1:0]          issue_rs2_tag,
    input  logic [DATA_W-1:0]         issue_rs2_data,
    input  logic [DATA_W-1:0]         issue_imm,
    output logic                      lsb_full,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    input  logic                      rob_commit,
    input  logic [TAG_W-1:0]          rob_commit_tag,
    input  logic [TAG_W-1:0]          rob_head_tag,
    input  logic                      flush,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [1:0]                mem_size,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
`ifdef LSB_STALL_CNT_EN
    output logic [31:0]               perf_stall_cnt,
`endif
    output logic                      res_valid,
    output logic [TAG_W-1:0]          res_tag,
    output logic [DATA_W-1:0]         res_data
);
    localparam int PTR_W = $clog2(LSB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    // Returns {hit, data} for the first valid CDB channel carrying a non-zero tag.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  t,
        input logic [NUM_CDB*DATA_W-1:0] d
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (!r[DATA_W] && v[c] && (tag != '0) && (t[c*TAG_W +: TAG_W] == tag))
                r = {1'b1, d[c*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    // Queue control
    logic [PTR_W-1:0]     head_reg, tail_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [LSB_DEPTH-1:0] busy_reg;

    // Entry payload (qualified by busy_reg, so no reset needed)
    logic [LSB_DEPTH-1:0] store_reg, commit_reg, notify_reg;
    logic [2:0]           funct3_reg   [LSB_DEPTH];
    logic [TAG_W-1:0]     dest_reg     [LSB_DEPTH];
    logic [TAG_W-1:0]     rs1_tag_reg  [LSB_DEPTH];
    logic [TAG_W-1:0]     rs2_tag_reg  [LSB_DEPTH];
    logic [DATA_W-1:0]    rs1_data_reg [LSB_DEPTH];
    logic [DATA_W-1:0]    rs2_data_reg [LSB_DEPTH];
    logic [DATA_W-1:0]    imm_reg      [LSB_DEPTH];

    // In-flight access bookkeeping
    state_t               state_reg, state_next;
    logic                 drop_reg;
    logic                 cur_store_reg;
    logic [2:0]           cur_funct3_reg;
    logic [TAG_W-1:0]     cur_dest_reg;

    logic [DATA_W:0]      wake1 [LSB_DEPTH];
    logic [DATA_W:0]      wake2 [LSB_DEPTH];
    logic [PTR_W-1:0]     offs  [LSB_DEPTH];
    logic [LSB_DEPTH-1:0] keep, commit_hit;
    logic [DATA_W:0]      iss1, iss2;
    logic [CNT_W-1:0]     ncommit;
    logic                 notify_found, notify_fire;
    logic [PTR_W-1:0]     notify_idx;
    logic [DATA_W-1:0]    head_addr, head_wdata, load_ext;
    logic                 head_elig, launch, pop, drop, issue_acc;

    assign lsb_full = (count_reg == CNT_W'(LSB_DEPTH));

    // Per-entry wake-up matches, commit matches and flush survivors
    for (genvar gi = 0; gi < LSB_DEPTH; gi++) begin : g_entry
        assign wake1[gi]      = cdb_lookup(rs1_tag_reg[gi], cdb_valid, cdb_tag, cdb_data);
        assign wake2[gi]      = cdb_lookup(rs2_tag_reg[gi], cdb_valid, cdb_tag, cdb_data);
        assign commit_hit[gi] = rob_commit && !flush && busy_reg[gi] && store_reg[gi]
                                && (dest_reg[gi] == rob_commit_tag);
        assign offs[gi]       = PTR_W'(gi) - head_reg;
        assign keep[gi]       = busy_reg[gi] && ({1'b0, offs[gi]} < ncommit);
    end

    assign iss1 = cdb_lookup(issue_rs1_tag, cdb_valid, cdb_tag, cdb_data);
    assign iss2 = cdb_lookup(issue_rs2_tag, cdb_valid, cdb_tag, cdb_data);

    // Scan from head: committed-store prefix length and oldest store awaiting notify
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             run;
        idx          = '0;
        run          = 1'b1;
        ncommit      = '0;
        notify_found = 1'b0;
        notify_idx   = '0;
        for (int i = 0; i < LSB_DEPTH; i++) begin
            idx = head_reg + PTR_W'(i);
            if (run && busy_reg[idx] && store_reg[idx] && commit_reg[idx])
                ncommit = ncommit + CNT_W'(1);
            else
                run = 1'b0;
            if (!notify_found && busy_reg[idx] && store_reg[idx] && !notify_reg[idx]
                && (rs1_tag_reg[idx] == '0) && (rs2_tag_reg[idx] == '0)) begin
                notify_found = 1'b1;
                notify_idx   = idx;
            end
        end
    end

    // Head address, store data alignment, eligibility and load extension
    always_comb begin
        head_addr  = rs1_data_reg[head_reg] + imm_reg[head_reg];
        head_wdata = rs2_data_reg[head_reg];
        case (funct3_reg[head_reg][1:0])
            2'b00:   head_wdata = {{(DATA_W-8){1'b0}},  rs2_data_reg[head_reg][7:0]};
            2'b01:   head_wdata = {{(DATA_W-16){1'b0}}, rs2_data_reg[head_reg][15:0]};
            default: head_wdata = rs2_data_reg[head_reg];
        endcase
        head_elig = busy_reg[head_reg] && (rs1_tag_reg[head_reg] == '0)
                    && (store_reg[head_reg]
                        ? ((rs2_tag_reg[head_reg] == '0) && commit_reg[head_reg])
                        : ((head_addr[17:16] != 2'b11) || (dest_reg[head_reg] == rob_head_tag)));
        case (cur_funct3_reg)
            3'b000:  load_ext = {{(DATA_W-8){mem_rdata[7]}},   mem_rdata[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}},  mem_rdata[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // FSM next state: launch from IDLE, complete (pop or drop) on ack in WAIT
    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        if (rdy) begin
            case (state_reg)
                IDLE: if (head_elig && !flush) begin
                    launch     = 1'b1;
                    state_next = WAIT;
                end
                WAIT: if (mem_ack) begin
                    drop       = drop_reg || (flush && !cur_store_reg);
                    pop        = !drop;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign issue_acc   = rdy && issue_valid && !flush && (!lsb_full || pop);
    assign notify_fire = rdy && !flush && notify_found && !(pop && !cur_store_reg);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Pointers, occupancy and busy bits; flush keeps only the committed prefix
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy_reg <= keep;
                if (pop) busy_reg[head_reg] <= 1'b0;
                head_reg  <= head_reg + PTR_W'(pop);
                tail_reg  <= head_reg + ncommit[PTR_W-1:0];
                count_reg <= ncommit - CNT_W'(pop);
            end else begin
                if (pop) begin
                    busy_reg[head_reg] <= 1'b0;
                    head_reg           <= head_reg + PTR_W'(1);
                end
                if (issue_acc) begin
                    busy_reg[tail_reg] <= 1'b1;
                    tail_reg           <= tail_reg + PTR_W'(1);
                end
                count_reg <= count_reg + CNT_W'(issue_acc) - CNT_W'(pop);
            end
        end
    end

    // Entry payload: wake-ups, commit marks, notify marks, then issue write (wins)
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < LSB_DEPTH; i++) begin
                if (busy_reg[i] && wake1[i][DATA_W]) begin
                    rs1_tag_reg[i]  <= '0;
                    rs1_data_reg[i] <= wake1[i][DATA_W-1:0];
                end
                if (busy_reg[i] && wake2[i][DATA_W]) begin
                    rs2_tag_reg[i]  <= '0;
                    rs2_data_reg[i] <= wake2[i][DATA_W-1:0];
                end
                if (commit_hit[i]) commit_reg[i] <= 1'b1;
            end
            if (notify_fire) notify_reg[notify_idx] <= 1'b1;
            if (issue_acc) begin
                store_reg[tail_reg]    <= issue_is_store;
                commit_reg[tail_reg]   <= 1'b0;
                notify_reg[tail_reg]   <= 1'b0;
                funct3_reg[tail_reg]   <= issue_funct3;
                dest_reg[tail_reg]     <= issue_dest;
                imm_reg[tail_reg]      <= issue_imm;
                rs1_tag_reg[tail_reg]  <= iss1[DATA_W] ? '0 : issue_rs1_tag;
                rs1_data_reg[tail_reg] <= iss1[DATA_W] ? iss1[DATA_W-1:0] : issue_rs1_data;
                rs2_tag_reg[tail_reg]  <= iss2[DATA_W] ? '0 : issue_rs2_tag;
                rs2_data_reg[tail_reg] <= iss2[DATA_W] ? iss2[DATA_W-1:0] : issue_rs2_data;
            end
        end
    end

    // Registered memory request, in-flight bookkeeping and result broadcast
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_size       <= '0;
            drop_reg       <= 1'b0;
            cur_store_reg  <= 1'b0;
            cur_funct3_reg <= '0;
            cur_dest_reg   <= '0;
            res_valid      <= 1'b0;
            res_tag        <= '0;
            res_data       <= '0;
        end else if (rdy) begin
            if (launch) begin
                mem_req        <= 1'b1;
                mem_we         <= store_reg[head_reg];
                mem_addr       <= head_addr;
                mem_wdata      <= head_wdata;
                mem_size       <= funct3_reg[head_reg][1:0];
                cur_store_reg  <= store_reg[head_reg];
                cur_funct3_reg <= funct3_reg[head_reg];
                cur_dest_reg   <= dest_reg[head_reg];
                drop_reg       <= 1'b0;
            end else if (state_reg == WAIT && mem_ack) begin
                mem_req  <= 1'b0;
                drop_reg <= 1'b0;
            end else if (state_reg == WAIT && flush && !cur_store_reg) begin
                drop_reg <= 1'b1;
            end
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
            if (pop && !cur_store_reg) begin
                res_valid <= 1'b1;
                res_tag   <= cur_dest_reg;
                res_data  <= load_ext;
            end else if (notify_fire) begin
                res_valid <= 1'b1;
                res_tag   <= dest_reg[notify_idx];
            end
        end
    end

`ifdef LSB_STALL_CNT_EN
    // Count rdy cycles where work is queued but the head cannot launch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_stall_cnt <= '0;
        else if (rdy && (count_reg != '0) && (state_reg == IDLE) && !head_elig)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_lsb_queue.sv
// tb_lsb_queue: directed self-checking bench for lsb_queue.
module tb_lsb_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_is_store;
    logic [2:0]  issue_funct3;
    logic [4:0]  issue_rs1_tag;
    logic [31:0] issue_rs1_data;
    logic [4:0]  issue_rs2_tag;
    logic [31:0] issue_rs2_data;
    logic [31:0] issue_imm;
    logic        lsb_full;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        rob_commit;
    logic [4:0]  rob_commit_tag;
    logic [4:0]  rob_head_tag;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic [4:0]  res_tag;
    logic [31:0] res_data;

    int tests_run    = 0;
    int tests_failed = 0;

    lsb_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_is_store(issue_is_store),
        .issue_funct3(issue_funct3), .issue_rs1_tag(issue_rs1_tag), .issue_rs1_data(issue_rs1_data),
        .issue_rs2_tag(issue_rs2_tag), .issue_rs2_data(issue_rs2_data), .issue_imm(issue_imm),
        .lsb_full(lsb_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_commit(rob_commit), .rob_commit_tag(rob_commit_tag), .rob_head_tag(rob_head_tag),
        .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic do_issue(input logic [4:0] dest, input logic st, input logic [2:0] f3,
                            input logic [4:0] t1, input logic [31:0] d1,
                            input logic [4:0] t2, input logic [31:0] d2, input logic [31:0] imm);
        issue_valid = 1'b1; issue_dest = dest; issue_is_store = st; issue_funct3 = f3;
        issue_rs1_tag = t1; issue_rs1_data = d1; issue_rs2_tag = t2; issue_rs2_data = d2;
        issue_imm = imm;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] rdata);
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; issue_valid = 1'b0; issue_dest = '0; issue_is_store = 1'b0;
        issue_funct3 = '0; issue_rs1_tag = '0; issue_rs1_data = '0; issue_rs2_tag = '0;
        issue_rs2_data = '0; issue_imm = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        rob_commit = 1'b0; rob_commit_tag = '0; rob_head_tag = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_full",      32'(lsb_full),  32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        rst = 1'b1;
        tick();

        // 1: LW tag3 at 0x100+4
        do_issue(5'd3, 1'b0, 3'b010, 5'd0, 32'h100, 5'd0, 32'd0, 32'd4);
        chk("t1_req_early", 32'(mem_req), 32'd0);
        tick();
        chk("t1_req",  32'(mem_req),  32'd1);
        chk("t1_addr", mem_addr,      32'h104);
        chk("t1_size", 32'(mem_size), 32'd2);
        chk("t1_we",   32'(mem_we),   32'd0);
        do_ack(32'hDEADBEEF);
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_tag",   32'(res_tag),   32'd3);
        chk("t1_res_data",  res_data,       32'hDEADBEEF);
        chk("t1_req_drop",  32'(mem_req),   32'd0);
        tick();
        chk("t1_res_pulse", 32'(res_valid), 32'd0);

        // 2: LB / LBU / LH extension
        do_issue(5'd4, 1'b0, 3'b000, 5'd0, 32'h200, 5'd0, 32'd0, 32'd0);
        tick();
        chk("t2_lb_size", 32'(mem_size), 32'd0);
        do_ack(32'h80);
        chk("t2_lb_data", res_data, 32'hFFFFFF80);
        do_issue(5'd6, 1'b0, 3'b100, 5'd0, 32'h200, 5'd0, 32'd0, 32'd0);
        tick();
        do_ack(32'h80);
        chk("t2_lbu_tag",  32'(res_tag), 32'd6);
        chk("t2_lbu_data", res_data,     32'h00000080);
        do_issue(5'd13, 1'b0, 3'b001, 5'd0, 32'h300, 5'd0, 32'd0, 32'd2);
        tick();
        chk("t2_lh_size", 32'(mem_size), 32'd1);
        chk("t2_lh_addr", mem_addr,      32'h302);
        do_ack(32'h00018001);
        chk("t2_lh_data", res_data, 32'hFFFF8001);

        // 3: SW tag5 waits for tag7 on CDB ch1, notifies, then commits
        do_issue(5'd5, 1'b1, 3'b010, 5'd0, 32'h400, 5'd7, 32'd0, 32'd0);
        tick(); tick();
        chk("t3_no_req",    32'(mem_req),   32'd0);
        chk("t3_no_notify", 32'(res_valid), 32'd0);
        cdb_valid = 2'b10; cdb_tag = {5'd7, 5'd0}; cdb_data = {32'h55, 32'h0};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("t3_notify_valid", 32'(res_valid), 32'd1);
        chk("t3_notify_tag",   32'(res_tag),   32'd5);
        chk("t3_notify_data",  res_data,       32'd0);
        tick();
        chk("t3_notify_once", 32'(res_valid), 32'd0);
        chk("t3_uncommitted", 32'(mem_req),   32'd0);
        rob_commit = 1'b1; rob_commit_tag = 5'd5;
        tick();
        rob_commit = 1'b0;
        tick();
        chk("t3_req",   32'(mem_req), 32'd1);
        chk("t3_we",    32'(mem_we),  32'd1);
        chk("t3_wdata", mem_wdata,    32'h55);
        chk("t3_addr",  mem_addr,     32'h400);
        do_ack(32'd0);
        chk("t3_store_no_res", 32'(res_valid), 32'd0);

        // 4: fill 16 pending loads, 17th ignored, pop+issue keeps full, drain in order
        for (int i = 1; i <= 16; i++) begin
            do_issue(5'(i), 1'b0, 3'b010, 5'd20, 32'd0, 5'd0, 32'd0, 32'(i * 4));
            if (i == 15) chk("t4_not_full_15", 32'(lsb_full), 32'd0);
        end
        chk("t4_full", 32'(lsb_full), 32'd1);
        do_issue(5'd30, 1'b0, 3'b010, 5'd20, 32'd0, 5'd0, 32'd0, 32'd0);
        chk("t4_full_after_17th", 32'(lsb_full), 32'd1);
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd20}; cdb_data = {32'h0, 32'h1000};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("t4_head_addr", mem_addr, 32'h1004);
        mem_ack = 1'b1; mem_rdata = 32'd1;
        issue_valid = 1'b1; issue_dest = 5'd17; issue_is_store = 1'b0; issue_funct3 = 3'b010;
        issue_rs1_tag = 5'd0; issue_rs1_data = 32'h2000; issue_imm = 32'd0;
        tick();
        mem_ack = 1'b0; issue_valid = 1'b0;
        chk("t4_pop_tag",       32'(res_tag),  32'd1);
        chk("t4_full_pop_issue", 32'(lsb_full), 32'd1);
        for (int t = 2; t <= 17; t++) begin
            tick();
            chk("t4_drain_addr", mem_addr, (t == 17) ? 32'h2000 : 32'(32'h1000 + t * 4));
            do_ack(32'(t));
            chk("t4_drain_tag", 32'(res_tag), 32'(t));
        end
        tick(); tick();
        chk("t4_empty_no_req", 32'(mem_req),  32'd0);
        chk("t4_empty_full",   32'(lsb_full), 32'd0);

        // 5: committed SW in flight, two loads behind, flush
        do_issue(5'd8,  1'b1, 3'b010, 5'd0, 32'h500, 5'd0, 32'h77, 32'd0);
        do_issue(5'd9,  1'b0, 3'b010, 5'd0, 32'h600, 5'd0, 32'd0,  32'd0);
        chk("t5_notify_tag", 32'(res_tag), 32'd8);
        do_issue(5'd10, 1'b0, 3'b010, 5'd0, 32'h700, 5'd0, 32'd0,  32'd0);
        rob_commit = 1'b1; rob_commit_tag = 5'd8;
        tick();
        rob_commit = 1'b0;
        tick();
        chk("t5_req_we",  32'(mem_we), 32'd1);
        chk("t5_wdata",   mem_wdata,   32'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_req_held", 32'(mem_req), 32'd1);
        do_ack(32'd0);
        chk("t5_ack_no_res", 32'(res_valid), 32'd0);
        repeat (3) begin
            tick();
            chk("t5_squashed_req", 32'(mem_req),   32'd0);
            chk("t5_squashed_res", 32'(res_valid), 32'd0);
        end

        // 5b: in-flight load flushed -> bus completes, result dropped
        do_issue(5'd11, 1'b0, 3'b010, 5'd0, 32'h800, 5'd0, 32'd0, 32'd0);
        tick();
        chk("t5b_req", 32'(mem_req), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do_ack(32'h1234);
        chk("t5b_dropped", 32'(res_valid), 32'd0);
        tick();
        chk("t5b_idle", 32'(mem_req), 32'd0);

        // 6: IO-space load waits for ROB head
        do_issue(5'd12, 1'b0, 3'b010, 5'd0, 32'h30000, 5'd0, 32'd0, 32'd0);
        tick(); tick(); tick();
        chk("t6_io_wait", 32'(mem_req), 32'd0);
        rob_head_tag = 5'd12;
        tick();
        chk("t6_io_req",  32'(mem_req), 32'd1);
        chk("t6_io_addr", mem_addr,     32'h30000);
        do_ack(32'h12345678);
        chk("t6_res_tag",  32'(res_tag), 32'd12);
        chk("t6_res_data", res_data,     32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
